// File: rtl/branch_fb_queue_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : mips_core_pkg                                                     |
// | Brief  : Shared core types for the branch feedback queue and predictor.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_core_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int G_HISTORY_BITS   = 8;
    localparam int BRANCH_FBQ_DEPTH = 8;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic [1:0] {
        FBQ_FREE     = 2'd0,
        FBQ_PENDING  = 2'd1,
        FBQ_RESOLVED = 2'd2
    } fbq_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     pc;
        logic [G_HISTORY_BITS-1:0] ghistory;
        BranchOutcome              pred;
        logic                      pred_gshare;
        logic                      pred_2bit;
        logic [ADDR_WIDTH-1:0]     recovery_pc;
        BranchOutcome              outcome;
    } branch_fb_entry_t;

endpackage

`default_nettype wire

// File: rtl/branch_fb_queue_if.sv
// +----------------------------------------------------------------------------+
// | Module : branch_fb_queue_if                                                |
// | Brief  : Decode/execute/predictor-feedback bundle of the branch queue.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface branch_fb_queue_if #(
    parameter int DEPTH = mips_core_pkg::BRANCH_FBQ_DEPTH
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int AW    = mips_core_pkg::ADDR_WIDTH;
    localparam int GW    = mips_core_pkg::G_HISTORY_BITS;

    logic             alloc_valid;
    logic             alloc_ready;
    logic [AW-1:0]    alloc_pc;
    logic [GW-1:0]    alloc_ghistory;
    logic             alloc_pred;
    logic             alloc_pred_gshare;
    logic             alloc_pred_2bit;
    logic [AW-1:0]    alloc_recovery_pc;
    logic [TAG_W-1:0] alloc_tag;

    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             resolve_outcome;

    logic             fb_valid;
    logic [AW-1:0]    fb_pc;
    logic [GW-1:0]    fb_ghistory;
    logic             fb_pred;
    logic             fb_pred_gshare;
    logic             fb_pred_2bit;
    logic             fb_outcome;
    logic             mispredict;
    logic [AW-1:0]    redirect_pc;
    logic [TAG_W:0]   count;

    modport master (
        output alloc_valid, alloc_pc, alloc_ghistory, alloc_pred, alloc_pred_gshare,
               alloc_pred_2bit, alloc_recovery_pc, resolve_valid, resolve_tag, resolve_outcome,
        input  alloc_ready, alloc_tag, fb_valid, fb_pc, fb_ghistory, fb_pred, fb_pred_gshare,
               fb_pred_2bit, fb_outcome, mispredict, redirect_pc, count
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_ghistory, alloc_pred, alloc_pred_gshare,
               alloc_pred_2bit, alloc_recovery_pc, resolve_valid, resolve_tag, resolve_outcome,
        output alloc_ready, alloc_tag, fb_valid, fb_pc, fb_ghistory, fb_pred, fb_pred_gshare,
               fb_pred_2bit, fb_outcome, mispredict, redirect_pc, count
    );

endinterface

`default_nettype wire

// File: rtl/branch_fb_queue.sv
// +----------------------------------------------------------------------------+
// | Module : branch_fb_queue                                                   |
// | Brief  : In-order queue of in-flight branches; out-of-order resolve,       |
// |          in-order retire into predictor feedback with mispredict flush.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_fb_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH = BRANCH_FBQ_DEPTH
) (
    input  wire logic         clk,
    input  wire logic         rst,
    branch_fb_queue_if.slave  bus
);

    localparam int             IDX_W   = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [IDX_W:0]        head_q, head_d, tail_q, tail_d;
    fbq_state_t            state_q [DEPTH];
    fbq_state_t            state_d [DEPTH];
    branch_fb_entry_t      entry_q [DEPTH];
    branch_fb_entry_t      entry_d [DEPTH];
    branch_fb_entry_t      fb_q, fb_d;
    logic                  fb_valid_q, fb_valid_d;
    logic                  mispredict_q, mispredict_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic [IDX_W-1:0]      w_head_idx, w_tail_idx;
    logic                  w_full, w_pop, w_pop_mis, w_alloc_ready, w_alloc;

    always_comb begin
        w_head_idx    = head_q[IDX_W-1:0];
        w_tail_idx    = tail_q[IDX_W-1:0];
        w_full        = (w_head_idx == w_tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
        w_pop         = (state_q[w_head_idx] == FBQ_RESOLVED);
        w_pop_mis     = w_pop && (entry_q[w_head_idx].outcome != entry_q[w_head_idx].pred);
        // A mispredicting retire flushes the queue, so nothing may enter behind it.
        w_alloc_ready = !w_full && !w_pop_mis;
        w_alloc       = bus.alloc_valid && w_alloc_ready;

        head_d        = head_q;
        tail_d        = tail_q;
        state_d       = state_q;
        entry_d       = entry_q;
        fb_d          = fb_q;
        fb_valid_d    = 1'b0;
        mispredict_d  = 1'b0;
        redirect_pc_d = redirect_pc_q;

        if (bus.resolve_valid && (state_q[bus.resolve_tag] == FBQ_PENDING)) begin
            entry_d[bus.resolve_tag].outcome = BranchOutcome'(bus.resolve_outcome);
            state_d[bus.resolve_tag]         = FBQ_RESOLVED;
        end

        if (w_alloc) begin
            entry_d[w_tail_idx] = '{
                pc:          bus.alloc_pc,
                ghistory:    bus.alloc_ghistory,
                pred:        BranchOutcome'(bus.alloc_pred),
                pred_gshare: bus.alloc_pred_gshare,
                pred_2bit:   bus.alloc_pred_2bit,
                recovery_pc: bus.alloc_recovery_pc,
                outcome:     NOT_TAKEN
            };
            state_d[w_tail_idx] = FBQ_PENDING;
            tail_d              = tail_q + PTR_ONE;
        end

        if (w_pop) begin
            fb_d                = entry_q[w_head_idx];
            fb_valid_d          = 1'b1;
            mispredict_d        = w_pop_mis;
            redirect_pc_d       = w_pop_mis ? entry_q[w_head_idx].recovery_pc : '0;
            state_d[w_head_idx] = FBQ_FREE;
            head_d              = head_q + PTR_ONE;
        end

        // Flush: overrides any same-edge resolve and leaves head == tail next cycle.
        if (w_pop_mis) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_d[i] = FBQ_FREE;
            end
            tail_d = head_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            fb_q          <= '0;
            fb_valid_q    <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= FBQ_FREE;
                entry_q[i] <= '0;
            end
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            fb_q          <= fb_d;
            fb_valid_q    <= fb_valid_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            state_q       <= state_d;
            entry_q       <= entry_d;
        end
    end

    assign bus.alloc_ready    = w_alloc_ready;
    assign bus.alloc_tag      = w_tail_idx;
    assign bus.count          = tail_q - head_q;
    assign bus.fb_valid       = fb_valid_q;
    assign bus.fb_pc          = fb_q.pc;
    assign bus.fb_ghistory    = fb_q.ghistory;
    assign bus.fb_pred        = fb_q.pred;
    assign bus.fb_pred_gshare = fb_q.pred_gshare;
    assign bus.fb_pred_2bit   = fb_q.pred_2bit;
    assign bus.fb_outcome     = fb_q.outcome;
    assign bus.mispredict     = mispredict_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_fb_queue.sv
// +----------------------------------------------------------------------------+
// | Module : tb_branch_fb_queue                                                |
// | Brief  : Self-checking bench: vector table, corner sequences, random run.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_branch_fb_queue;
    import mips_core_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_fb_queue_if #(.DEPTH(DEPTH)) bus ();

    branch_fb_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: an ordered list of in-flight branches, each remembering its tag.
    typedef struct {
        logic [31:0] pc;
        logic [7:0]  gh;
        logic        pred;
        logic        pg;
        logic        p2;
        logic [31:0] rpc;
        int          tag;
        bit          res;
        logic        outc;
    } ment_t;

    ment_t       mq[$];
    int          next_tag;
    logic        e_valid, e_mis, e_pred, e_pg, e_p2, e_outc;
    logic [31:0] e_pc, e_redirect;
    logic [7:0]  e_gh;

    typedef struct {
        logic        av;
        logic [31:0] pc;
        logic        pred;
        logic        rv;
        int          rt;
        logic        ro;
        logic        x_valid;
        logic [31:0] x_pc;
        logic        x_mis;
        int          x_count;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        next_tag   = 0;
        e_valid    = 1'b0;
        e_mis      = 1'b0;
        e_pred     = 1'b0;
        e_pg       = 1'b0;
        e_p2       = 1'b0;
        e_outc     = 1'b0;
        e_pc       = '0;
        e_redirect = '0;
        e_gh       = '0;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid       = 1'b0;
        bus.alloc_pc          = '0;
        bus.alloc_ghistory    = '0;
        bus.alloc_pred        = 1'b0;
        bus.alloc_pred_gshare = 1'b0;
        bus.alloc_pred_2bit   = 1'b0;
        bus.alloc_recovery_pc = '0;
        bus.resolve_valid     = 1'b0;
        bus.resolve_tag       = '0;
        bus.resolve_outcome   = 1'b0;
    endtask

    // One clock: check pre-edge state, drive, advance the model, check registered outputs.
    task automatic cycle(input logic av, input logic [31:0] pc, input logic pred,
                         input logic rv, input int rt, input logic ro);
        bit    pop, mis, ready;
        ment_t n;
        pop   = (mq.size() > 0) && mq[0].res;
        mis   = pop && (mq[0].outc != mq[0].pred);
        ready = (mq.size() < DEPTH) && !mis;
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(ready));
        chk("alloc_tag", 64'(bus.alloc_tag), 64'(next_tag));

        bus.alloc_valid       = av;
        bus.alloc_pc          = pc;
        bus.alloc_ghistory    = pc[9:2] ^ 8'h5a;
        bus.alloc_pred        = pred;
        bus.alloc_pred_gshare = pc[3];
        bus.alloc_pred_2bit   = ~pc[4];
        bus.alloc_recovery_pc = pc + 32'h100;
        bus.resolve_valid     = rv;
        bus.resolve_tag       = 3'(rt);
        bus.resolve_outcome   = ro;
        @(posedge clk);

        if (rv && !mis) begin
            foreach (mq[i]) begin
                if (mq[i].tag == rt && !mq[i].res) begin
                    mq[i].res  = 1'b1;
                    mq[i].outc = ro;
                end
            end
        end
        if (pop) begin
            e_valid    = 1'b1;
            e_mis      = mis;
            e_pc       = mq[0].pc;
            e_gh       = mq[0].gh;
            e_pred     = mq[0].pred;
            e_pg       = mq[0].pg;
            e_p2       = mq[0].p2;
            e_outc     = mq[0].outc;
            e_redirect = mis ? mq[0].rpc : 32'h0;
            if (mis) begin
                next_tag = (mq[0].tag + 1) % DEPTH;
                mq.delete();
            end else begin
                void'(mq.pop_front());
            end
        end else begin
            e_valid = 1'b0;
            e_mis   = 1'b0;
        end
        if (av && ready) begin
            n.pc   = pc;
            n.gh   = pc[9:2] ^ 8'h5a;
            n.pred = pred;
            n.pg   = pc[3];
            n.p2   = ~pc[4];
            n.rpc  = pc + 32'h100;
            n.tag  = next_tag;
            n.res  = 1'b0;
            n.outc = 1'b0;
            mq.push_back(n);
            next_tag = (next_tag + 1) % DEPTH;
        end

        #1;
        idle_inputs();
        chk("fb_valid", 64'(bus.fb_valid), 64'(e_valid));
        chk("mispredict", 64'(bus.mispredict), 64'(e_mis));
        chk("fb_pc", 64'(bus.fb_pc), 64'(e_pc));
        chk("fb_ghistory", 64'(bus.fb_ghistory), 64'(e_gh));
        chk("fb_pred", 64'(bus.fb_pred), 64'(e_pred));
        chk("fb_pred_gshare", 64'(bus.fb_pred_gshare), 64'(e_pg));
        chk("fb_pred_2bit", 64'(bus.fb_pred_2bit), 64'(e_p2));
        chk("fb_outcome", 64'(bus.fb_outcome), 64'(e_outc));
        chk("redirect_pc", 64'(bus.redirect_pc), 64'(e_redirect));
    endtask

    task automatic do_reset(input bit resolve_head);
        idle_inputs();
        if (resolve_head) begin
            bus.resolve_valid   = 1'b1;
            bus.resolve_tag     = '0;
            bus.resolve_outcome = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        chk("rst_alloc_tag", 64'(bus.alloc_tag), 64'd0);
        chk("rst_fb_valid", 64'(bus.fb_valid), 64'd0);
        chk("rst_mispredict", 64'(bus.mispredict), 64'd0);
        chk("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
        chk("rst_fb_pc", 64'(bus.fb_pc), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   k;
        logic av, pred, rv, ro;
        int   rt;
        logic [31:0] pc;

        //         av  pc           pred rv rt ro  fbv  fb_pc        mis cnt
        vt[0] = '{1'b1, 32'h1000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0,    1'b0, 1};
        vt[1] = '{1'b1, 32'h1004, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0,    1'b0, 2};
        vt[2] = '{1'b1, 32'h1008, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0,    1'b0, 3};
        vt[3] = '{1'b0, 32'h0,    1'b0, 1'b1, 2, 1'b1, 1'b0, 32'h0,    1'b0, 3};
        vt[4] = '{1'b0, 32'h0,    1'b0, 1'b1, 1, 1'b1, 1'b0, 32'h0,    1'b0, 3};
        vt[5] = '{1'b0, 32'h0,    1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0,    1'b0, 3};
        vt[6] = '{1'b0, 32'h0,    1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h1000, 1'b0, 2};
        vt[7] = '{1'b0, 32'h0,    1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h1004, 1'b0, 1};
        vt[8] = '{1'b0, 32'h0,    1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h1008, 1'b0, 0};
        vt[9] = '{1'b0, 32'h0,    1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h1008, 1'b0, 0};

        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].av, vt[i].pc, vt[i].pred, vt[i].rv, vt[i].rt, vt[i].ro);
            chk("tbl_fb_valid", 64'(bus.fb_valid), 64'(vt[i].x_valid));
            chk("tbl_fb_pc", 64'(bus.fb_pc), 64'(vt[i].x_pc));
            chk("tbl_mispredict", 64'(bus.mispredict), 64'(vt[i].x_mis));
            chk("tbl_count", 64'(bus.count), 64'(vt[i].x_count));
        end

        // Full queue: ninth allocation refused, tag wraps after one retire.
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h2000 + 32'(4 * i), 1'b1, 1'b0, 0, 1'b0);
        chk("full_ready", 64'(bus.alloc_ready), 64'd0);
        chk("full_count", 64'(bus.count), 64'd8);
        cycle(1'b1, 32'h3000, 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("wrap_count", 64'(bus.count), 64'd7);
        chk("wrap_ready", 64'(bus.alloc_ready), 64'd1);
        chk("wrap_tag", 64'(bus.alloc_tag), 64'd0);

        // Mispredict on the head flushes everything behind it.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h400000 + 32'(16 * i), 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("mis_fb_valid", 64'(bus.fb_valid), 64'd1);
        chk("mis_flag", 64'(bus.mispredict), 64'd1);
        chk("mis_redirect", 64'(bus.redirect_pc), 64'h400100);
        chk("mis_count", 64'(bus.count), 64'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("mis_stale_resolve", 64'(bus.fb_valid), 64'd0);

        // Allocate, resolve and retire on the same edge.
        do_reset(1'b0);
        cycle(1'b1, 32'h5000, 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 32'h5004, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 32'h5008, 1'b1, 1'b1, 0, 1'b1);
        cycle(1'b1, 32'h500c, 1'b1, 1'b1, 1, 1'b0);
        chk("simul_count", 64'(bus.count), 64'd3);
        chk("simul_fb_pc", 64'(bus.fb_pc), 64'h5000);
        cycle(1'b1, 32'h5010, 1'b0, 1'b1, 2, 1'b1);
        chk("simul_count2", 64'(bus.count), 64'd3);
        for (int i = 3; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, i, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);

        // Reset with five pending entries: none of them may ever be fed back.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h6000 + 32'(4 * i), 1'b1, 1'b0, 0, 1'b0);
        for (int i = 1; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, i, 1'b1);
        do_reset(1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);

        // Random traffic against the reference list.
        do_reset(1'b0);
        for (int n = 0; n < 400; n++) begin
            av   = ($urandom % 10) < 6;
            pred = 1'($urandom);
            pc   = $urandom & 32'hffff_fffc;
            rv   = ($urandom % 2) == 1;
            if (mq.size() > 0 && ($urandom % 10) < 8) begin
                k  = int'($urandom % mq.size());
                rt = mq[k].tag;
                ro = (($urandom % 10) < 8) ? mq[k].pred : ~mq[k].pred;
            end else begin
                rt = int'($urandom_range(0, 7));
                ro = 1'($urandom);
            end
            cycle(av, pc, pred, rv, rt, ro);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
